ppu_arbiter: RTL

Two-requester round-robin arbiter that shares one pipelined `ppu_top` instance between two independent clients. It sits directly in front of the PPU, drives the PPU `ppu_valid_in`/`ppu_in1`/`ppu_in2`/`ppu_op` inputs, and keeps an in-order tag FIFO of issued requests. When the PPU raises `ppu_valid_o`, the arbiter returns `ppu_out` to the client that issued the corresponding operation. The PPU pipeline is in-order, so result order matches issue order.

---
 rtl/ppu_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ppu_arbiter.sv
// Two-client round-robin front end for a shared, in-order pipelined PPU.
// Keeps a tag FIFO of issued operations so each result goes back to the client that issued it.
module ppu_arbiter #(
    parameter int WORD    = 32,
    parameter int OP_SIZE = 3,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [WORD-1:0]            req0_in1,
    input  logic [WORD-1:0]            req0_in2,
    input  logic [OP_SIZE-1:0]         req0_op,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [WORD-1:0]            req1_in1,
    input  logic [WORD-1:0]            req1_in2,
    input  logic [OP_SIZE-1:0]         req1_op,
    output logic                       resp0_valid,
    output logic [WORD-1:0]            resp0_out,
    output logic                       resp1_valid,
    output logic [WORD-1:0]            resp1_out,
    output logic                       ppu_valid_in,
    output logic [WORD-1:0]            ppu_in1,
    output logic [WORD-1:0]            ppu_in2,
    output logic [OP_SIZE-1:0]         ppu_op,
    input  logic [WORD-1:0]            ppu_out,
    input  logic                       ppu_valid_o,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       err_orphan
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]      inflight_reg, inflight_next;
    logic               last_grant_reg;
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic               tag_mem [DEPTH];
    logic               err_orphan_reg;
    logic               ppu_valid_in_reg;
    logic [WORD-1:0]    ppu_in1_reg, ppu_in2_reg;
    logic [OP_SIZE-1:0] ppu_op_reg;
    logic               resp_valid_reg [2];
    logic [WORD-1:0]    resp_out_reg [2];

    logic not_full, push, push_tag, pop, head_tag;

    // Ready is held low in reset; full uses the registered count, so a same-cycle pop cannot re-enable it.
    assign not_full   = inflight_reg < CW'(DEPTH);
    assign req0_ready = !rst && req0_valid && not_full && (!req1_valid || last_grant_reg);
    assign req1_ready = !rst && req1_valid && not_full && (!req0_valid || !last_grant_reg);
    assign push       = req0_ready || req1_ready;
    assign push_tag   = req1_ready;
    assign pop        = ppu_valid_o && (inflight_reg != '0);
    assign head_tag   = tag_mem[rd_ptr_reg];

    always_comb begin
        inflight_next = inflight_reg;
        if (push && !pop)
            inflight_next = inflight_reg + CW'(1);
        else if (!push && pop)
            inflight_next = inflight_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg     <= '0;
            last_grant_reg   <= 1'b1;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            err_orphan_reg   <= 1'b0;
            ppu_valid_in_reg <= 1'b0;
            ppu_in1_reg      <= '0;
            ppu_in2_reg      <= '0;
            ppu_op_reg       <= '0;
        end else begin
            inflight_reg     <= inflight_next;
            ppu_valid_in_reg <= push;
            if (push) begin
                last_grant_reg <= push_tag;
                wr_ptr_reg     <= wr_ptr_reg + PW'(1);
                ppu_in1_reg    <= push_tag ? req1_in1 : req0_in1;
                ppu_in2_reg    <= push_tag ? req1_in2 : req0_in2;
                ppu_op_reg     <= push_tag ? req1_op  : req0_op;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (ppu_valid_o && inflight_reg == '0)
                err_orphan_reg <= 1'b1;
        end
    end

    // Tag storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr_reg] <= push_tag;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        always_ff @(posedge clk) begin
            if (rst) begin
                resp_valid_reg[gi] <= 1'b0;
                resp_out_reg[gi]   <= '0;
            end else begin
                resp_valid_reg[gi] <= pop && (head_tag == 1'(gi));
                if (pop && (head_tag == 1'(gi)))
                    resp_out_reg[gi] <= ppu_out;
            end
        end
    end

    assign resp0_valid  = resp_valid_reg[0];
    assign resp0_out    = resp_out_reg[0];
    assign resp1_valid  = resp_valid_reg[1];
    assign resp1_out    = resp_out_reg[1];
    assign ppu_valid_in = ppu_valid_in_reg;
    assign ppu_in1      = ppu_in1_reg;
    assign ppu_in2      = ppu_in2_reg;
    assign ppu_op       = ppu_op_reg;
    assign inflight     = inflight_reg;
    assign err_orphan   = err_orphan_reg;
endmodule
